// File: rtl/matrix_mac_engine.sv
// Sequential 3x3 unsigned matrix multiplier using a single multiply-accumulate unit.
// It reads A and B once, then streams each C element as it completes.
// It is busy for 30 cycles from the accepted start to the done pulse, and it ignores start while busy.
module matrix_mac_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_rd_en,
  input  logic [9*DATA_W-1:0]   a_data,
  input  logic [9*DATA_W-1:0]   b_data,
  output logic                  c_valid,
  output logic [3:0]            c_addr,
  output logic [ACC_W-1:0]      c_elem,
  output logic [9*ACC_W-1:0]    c_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_MAC     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [9*DATA_W-1:0] a_reg, b_reg;
  logic [ACC_W-1:0]    acc;
  logic [1:0]          i_cnt, j_cnt, k_cnt;

  // Operand registers unpacked into element arrays for indexed access
  logic [DATA_W-1:0]   a_arr [9];
  logic [DATA_W-1:0]   b_arr [9];

  genvar n;
  generate
    for (n = 0; n < 9; n++) begin : g_unpack
      assign a_arr[n] = a_reg[n*DATA_W +: DATA_W];
      assign b_arr[n] = b_reg[n*DATA_W +: DATA_W];
    end
  endgenerate

  logic [3:0]          a_idx, b_idx, elem_idx;
  logic [2*DATA_W-1:0] mul;
  logic [ACC_W-1:0]    prod;
  logic [ACC_W-1:0]    sum;
  logic                accept;
  logic                mac_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: fixed one-cycle fetch and capture, 27 MAC cycles, one done cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_MAC;
      S_MAC:     if (mac_last) state_nxt = S_IDLE == S_IDLE ? S_DONE : S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Decode and MAC datapath: current product and the running sum it produces
  always_comb begin
    accept   = (state == S_IDLE) && start;
    mac_last = (state == S_MAC) && (i_cnt == 2'd2) && (j_cnt == 2'd2) && (k_cnt == 2'd2);
    a_idx    = {2'b00, i_cnt} * 4'd3 + {2'b00, k_cnt};
    b_idx    = {2'b00, k_cnt} * 4'd3 + {2'b00, j_cnt};
    elem_idx = {2'b00, i_cnt} * 4'd3 + {2'b00, j_cnt};
    mul      = {{DATA_W{1'b0}}, a_arr[a_idx]} * {{DATA_W{1'b0}}, b_arr[b_idx]};
    prod     = ACC_W'(mul);
    sum      = ((k_cnt == 2'd0) ? '0 : acc) + prod;
  end

  // Registered outputs, operands, accumulator and i/j/k counters (k innermost)
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      c_valid   <= 1'b0;
      c_addr    <= '0;
      c_elem    <= '0;
      c_data    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      k_cnt     <= '0;
    end else begin
      mem_rd_en <= accept;
      done      <= (state == S_DONE);
      c_valid   <= 1'b0;
      if (accept)                busy <= 1'b1;
      else if (state == S_DONE)  busy <= 1'b0;

      case (state)
        S_CAPTURE: begin
          a_reg <= a_data;
          b_reg <= b_data;
          acc   <= '0;
          i_cnt <= '0;
          j_cnt <= '0;
          k_cnt <= '0;
        end
        S_MAC: begin
          acc <= sum;
          if (k_cnt == 2'd2) begin
            c_valid                          <= 1'b1;
            c_elem                           <= sum;
            c_addr                           <= elem_idx;
            c_data[elem_idx*ACC_W +: ACC_W]  <= sum;
            k_cnt                            <= '0;
            if (j_cnt == 2'd2) begin
              j_cnt <= '0;
              i_cnt <= i_cnt + 2'd1;
            end else begin
              j_cnt <= j_cnt + 2'd1;
            end
          end else begin
            k_cnt <= k_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mac_engine.sv
module tb_matrix_mac_engine;
  localparam int DW = 8;
  localparam int AW = 18;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               mem_rd_en;
  logic [9*DW-1:0]    a_data, b_data;
  logic               c_valid;
  logic [3:0]         c_addr;
  logic [AW-1:0]      c_elem;
  logic [9*AW-1:0]    c_data;
  logic               busy;
  logic               done;

  matrix_mac_engine #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_rd_en(mem_rd_en),
    .a_data(a_data), .b_data(b_data), .c_valid(c_valid), .c_addr(c_addr),
    .c_elem(c_elem), .c_data(c_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: tracks cycles since the accepted start and derives
  // every expected output from the operation timeline and plain matrix math.
  int unsigned am [9], bm [9], cm [9], cmod [9];
  bit          active    = 1'b0;
  bit          model_ok  = 1'b0;
  bit          exp_reset = 1'b0;
  int          t = 0;
  logic        exp_rd, exp_busy, exp_done, exp_valid;
  logic [3:0]  exp_addr;
  int unsigned exp_elem;

  always @(posedge clk) begin
    cyc++;
    model_ok  = 1'b1;
    exp_rd    = 1'b0;
    exp_done  = 1'b0;
    exp_valid = 1'b0;
    if (rst) begin
      active    = 1'b0;
      exp_reset = 1'b1;
      exp_busy  = 1'b0;
      exp_addr  = '0;
      exp_elem  = 0;
      for (int n = 0; n < 9; n++) cmod[n] = 0;
    end else begin
      exp_reset = 1'b0;
      if (active) begin
        t++;
        if (t == 2) begin
          for (int n = 0; n < 9; n++) begin
            am[n] = a_data[n*DW +: DW];
            bm[n] = b_data[n*DW +: DW];
          end
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
              cm[r*3+c] = 0;
              for (int q = 0; q < 3; q++) cm[r*3+c] += am[r*3+q] * bm[q*3+c];
            end
        end
        if (t >= 5 && t <= 29 && (t - 5) % 3 == 0) begin
          exp_valid          = 1'b1;
          exp_addr           = 4'((t - 5) / 3);
          exp_elem           = cm[(t-5)/3];
          cmod[(t-5)/3]      = cm[(t-5)/3];
        end
        if (t == 30) begin
          exp_done = 1'b1;
          exp_busy = 1'b0;
          active   = 1'b0;
        end
      end else if (start) begin
        active   = 1'b1;
        t        = 0;
        exp_rd   = 1'b1;
        exp_busy = 1'b1;
      end
    end
  end

  // Compare process: checks DUT outputs against the model away from the active edge
  always @(negedge clk) begin
    logic [9*AW-1:0] exp_cdata;
    if (model_ok) begin
      for (int n = 0; n < 9; n++) exp_cdata[n*AW +: AW] = AW'(cmod[n]);
      chk("mem_rd_en", mem_rd_en, exp_rd);
      chk("busy",      busy,      exp_busy);
      chk("done",      done,      exp_done);
      chk("c_valid",   c_valid,   exp_valid);
      chk("c_data",    c_data,    exp_cdata);
      if (exp_valid || exp_reset) begin
        chk("c_addr", c_addr, exp_addr);
        chk("c_elem", c_elem, exp_elem);
      end
    end
  end

  function automatic logic [9*DW-1:0] pack(input int unsigned v [9]);
    logic [9*DW-1:0] r;
    for (int n = 0; n < 9; n++) r[n*DW +: DW] = DW'(v[n]);
    return r;
  endfunction

  function automatic logic [9*DW-1:0] rnd_mat();
    logic [9*DW-1:0] r;
    for (int n = 0; n < 9; n++) r[n*DW +: DW] = DW'($urandom_range(0, 255));
    return r;
  endfunction

  // Hand-computed expectations for the packed result
  task automatic chk_lit(input string nm, input int unsigned v [9]);
    for (int n = 0; n < 9; n++)
      chk($sformatf("%s[%0d]", nm, n), c_data[n*AW +: AW], v[n]);
  endtask

  task automatic wait_done(input string nm, output int when);
    when = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) begin
        when = cyc;
        break;
      end
    end
    if (when < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done_within_60", nm);
    end
  endtask

  task automatic run_pulse(input string nm);
    int w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nm, w);
  endtask

  int unsigned v [9];
  int          t1, t2;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a_data = '0;
    b_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_cdata", c_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Identity times 1..9
    v = '{1,0,0, 0,1,0, 0,0,1}; a_data = pack(v);
    v = '{1,2,3, 4,5,6, 7,8,9}; b_data = pack(v);
    run_pulse("identity");
    v = '{1,2,3, 4,5,6, 7,8,9};
    chk_lit("identity_c", v);

    // General operands with input changes after capture and ignored start pulses
    v = '{1,2,3, 4,5,6, 7,8,9}; a_data = pack(v);
    v = '{9,8,7, 6,5,4, 3,2,1}; b_data = pack(v);
    start = 1'b1;
    @(negedge clk);               // after E0
    start = 1'b0;
    repeat (2) @(negedge clk);    // after E2
    a_data = rnd_mat();
    b_data = rnd_mat();
    repeat (7) @(negedge clk);    // after E9
    start = 1'b1;
    @(negedge clk);               // after E10
    start = 1'b0;
    repeat (19) @(negedge clk);   // after E29
    start = 1'b1;
    @(negedge clk);               // after E30
    chk("general_done", done, 1'b1);
    v = '{30,24,18, 84,69,54, 138,114,90};
    chk_lit("general_c", v);
    @(negedge clk);               // after E31: accepted
    start = 1'b0;
    wait_done("after_e31", t1);

    // Max values
    v = '{255,255,255, 255,255,255, 255,255,255};
    a_data = pack(v);
    b_data = pack(v);
    run_pulse("max");
    v = '{195075,195075,195075, 195075,195075,195075, 195075,195075,195075};
    chk_lit("max_c", v);

    // Reset in the middle of MAC
    a_data = rnd_mat();
    b_data = rnd_mat();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);   // after E11
    rst = 1'b1;
    @(negedge clk);               // after E12
    chk("midrst_cdata", c_data, 0);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    a_data = rnd_mat();
    b_data = rnd_mat();
    run_pulse("post_reset");

    // Back-to-back with start held high
    a_data = rnd_mat();
    b_data = rnd_mat();
    start = 1'b1;
    @(negedge clk);
    repeat (2) @(negedge clk);
    a_data = rnd_mat();
    b_data = rnd_mat();
    wait_done("b2b_first", t1);
    wait_done("b2b_second", t2);
    start = 1'b0;
    chk("b2b_period", 200'(t2 - t1), 31);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      a_data = rnd_mat();
      b_data = rnd_mat();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_pulse("random");
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
